// File: rtl/aes_wb_pkg.sv
// Shared types and constants for the AES result writeback block.
// Holds the FSM state encoding, the beat geometry and the DIR encodings.
package aes_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int NBEATS = 4;
    localparam int BEAT_W = 2;

    localparam logic DIR_ENC = 1'b0;
    localparam logic DIR_DEC = 1'b1;

endpackage

// File: rtl/aes_result_writeback_beat_mux.sv
// Combinational 128-to-32 word select: beat 0 -> bits [31:0], beat 3 -> bits [127:96].
module beat_mux
    import aes_wb_pkg::*;
(
    input  logic [127:0]      word_i,
    input  logic [BEAT_W-1:0] beat_i,
    output logic [31:0]       word_o
);

    assign word_o = word_i[32*beat_i +: 32];

endmodule

// File: rtl/aes_result_writeback.sv
// Collects a 128-bit AES/inverse-AES result and writes it to four consecutive
// general registers as 32-bit beats through a GRANT handshake.
module aes_result_writeback
    import aes_wb_pkg::*;
#(
    parameter int AES_LATENCY = 11,
    parameter int CNT_W       = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic         DIR,
    input  logic [4:0]   BASE,
    input  logic [127:0] AES_CIPHER,
    input  logic [127:0] AES_INVPLAIN,
    input  logic         GRANT,
    output logic         REQ,
    output logic [4:0]   A3,
    output logic [31:0]  WB,
    output logic         WE,
    output logic         BUSY,
    output logic         DONE
);

    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(AES_LATENCY - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [BEAT_W-1:0]   beat_q,  beat_d;
    logic [127:0]        hold_q,  hold_d;
    logic                dir_q,   dir_d;
    logic [4:0]          base_q,  base_d;

    logic                cap_dir;
    logic [127:0]        cap_word;
    logic [4:0]          wr_addr;
    logic [31:0]         beat_word;

    // In IDLE the capture path (only used when AES_LATENCY==1) sees DIR live.
    assign cap_dir  = (state_q == ST_IDLE) ? DIR : dir_q;
    assign cap_word = (cap_dir == DIR_DEC) ? AES_INVPLAIN : AES_CIPHER;

    // 5-bit add wraps naturally: BASE=30 targets r30, r31, r0, r1.
    assign wr_addr = base_q + 5'(beat_q);

    beat_mux u_beat_mux (
        .word_i (hold_q),
        .beat_i (beat_q),
        .word_o (beat_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the holding register is reset too, because it
    // drives WB and must read as zero after an abort.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            hold_q  <= '0;
            dir_q   <= 1'b0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            hold_q  <= hold_d;
            dir_q   <= dir_d;
            base_q  <= base_d;
        end
    end

    // NOTE: every signal gets a hold-value default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        hold_d  = hold_q;
        dir_d   = dir_q;
        base_d  = base_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    dir_d  = DIR;
                    base_d = BASE;
                    cnt_d  = CNT_LOAD;
                    if (AES_LATENCY == 1) begin
                        hold_d  = cap_word;
                        beat_d  = '0;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Capture on the edge where the counter steps to zero.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    hold_d  = cap_word;
                    beat_d  = '0;
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WRITE: begin
                if (GRANT) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        REQ  = 1'b0;
        A3   = '0;
        WB   = '0;
        WE   = 1'b0;
        BUSY = 1'b0;
        DONE = 1'b0;

        case (state_q)
            ST_WAIT: begin
                BUSY = 1'b1;
            end
            ST_WRITE: begin
                BUSY = 1'b1;
                REQ  = 1'b1;
                A3   = wr_addr;
                WB   = beat_word;
                // A beat aimed at r0 is consumed without a write so x0 stays zero.
                WE   = GRANT && (wr_addr != 5'd0);
            end
            ST_DONE: begin
                BUSY = 1'b1;
                DONE = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
